imem_boot_loader: RTL and testbench

Boot-time controller that sequences the single-cycle RV32I core (`riscv_toplevel`). It holds the core in reset and loads a program image into instruction memory from a byte-stream source (UART receiver or bench driver). It verifies the image and then releases the core. It sits beside the core at the top level, owning the instruction-memory write port and the core's reset.

---
 rtl/boot_pkg.sv | 9 +
 rtl/boot_byte_packer.sv | 32 +++
 rtl/imem_boot_loader.sv | 105 ++++++++++
 tb/tb_imem_boot_loader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: shared states, error codes and stream constants for the boot loader
package boot_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERROR} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/boot_byte_packer.sv
// boot_byte_packer: assembles little-endian bytes into 32-bit words with a one-cycle valid pulse
module boot_byte_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [1:0]        lane,
  output logic [31:0]       word,
  output logic              word_valid
);
  logic [23:0] asm_q;
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      lane       <= '0;
      asm_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && lane == 2'd3;
      if (clr) begin
        lane  <= '0;
        asm_q <= '0;
      end else if (en) begin
        lane  <= lane + 2'd1;
        asm_q <= {data, asm_q[23:8]};
        if (lane == 2'd3) word <= {data, asm_q};
      end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length/data/checksum byte stream into imem and releases the core
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);
  state_t state;
  logic [15:0] len, n;
  logic [7:0] csum;
  logic [ADDR_W:0] idx, idx_nxt;
  logic [1:0] lane;
  logic acc, go, n_ok;
  assign acc     = rx_valid && rx_ready;
  assign go      = start && !busy;
  assign n       = {rx_data, len[7:0]};
  assign n_ok    = n >= 16'd1 && n <= 16'(IMEM_DEPTH);
  assign idx_nxt = idx + 1'b1;
  boot_byte_packer u_packer (
    .clk       (clk),
    .rst_      (rst_),
    .clr       (go),
    .en        (acc && state == S_DATA),
    .data      (rx_data),
    .lane      (lane),
    .word      (imem_wdata),
    .word_valid(imem_we)
  );
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      core_rst_ <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= ERR_NONE;
      len       <= '0;
      csum      <= '0;
      idx       <= '0;
      imem_addr <= '0;
    end else if (go) begin
      state     <= S_LEN0;
      rx_ready  <= 1'b1;
      core_rst_ <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      err_code  <= ERR_NONE;
      len       <= '0;
      csum      <= '0;
      idx       <= '0;
    end else if (acc) begin
      case (state)
        S_LEN0: begin
          len[7:0] <= rx_data;
          state    <= S_LEN1;
        end
        S_LEN1: begin
          if (n_ok) begin
            len   <= n;
            state <= S_DATA;
          end else begin
            state    <= S_ERROR;
            err_code <= ERR_LEN;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
          end
        end
        S_DATA: begin
          csum <= csum ^ rx_data;
          if (lane == 2'd3) begin
            imem_addr <= idx[ADDR_W-1:0];
            idx       <= idx_nxt;
            if (16'(idx_nxt) == len) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          if (csum == rx_data) begin
            state     <= S_RUN;
            core_rst_ <= 1'b1;
            done      <= 1'b1;
          end else begin
            state    <= S_ERROR;
            err_code <= ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed scoreboard bench for the boot loader
module tb_imem_boot_loader;
  localparam int IMEM_DEPTH = 256;
  localparam int ADDR_W = 8;
  logic clk = 1'b0, rst_ = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, imem_we, core_rst_, busy, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0] err_code;
  int checks = 0, failures = 0, we_cnt = 0;
  logic [ADDR_W+31:0] sb[$];
  logic [31:0] img[2] = '{32'h00500093, 32'h00A00113};
  always #5 clk = ~clk;
  imem_boot_loader #(.IMEM_DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_(rst_), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_(core_rst_), .busy(busy), .done(done), .err_code(err_code)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (rst_ && imem_we) begin
    we_cnt++;
    if (sb.size() == 0) check("unexpected_we", {imem_addr, imem_wdata}, 'x);
    else check("imem_write", {imem_addr, imem_wdata}, sb.pop_front());
  end
  task automatic send_byte(input logic [7:0] b, input bit thr);
    int t;
    bit got;
    t = 0;
    got = 1'b0;
    if (thr) begin
      rx_valid = 1'b0;
      rx_data = $urandom_range(0, 255);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    while (!got && t < 50) begin
      @(negedge clk);
      if (rx_ready) got = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    rx_valid = 1'b0;
    if (!got) check("rx_timeout", 0, 1);
  endtask
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic send_image(input bit thr, input bit bad_csum);
    logic [7:0] cs;
    logic [31:0] w;
    cs = 8'h00;
    send_byte(8'h02, thr);
    send_byte(8'h00, thr);
    check("rx_ready_after_len", rx_ready, 1);
    for (int i = 0; i < 2; i++) begin
      w = img[i];
      sb.push_back({ADDR_W'(i), w});
      for (int k = 0; k < 4; k++) begin
        cs ^= w[8*k +: 8];
        send_byte(w[8*k +: 8], thr);
      end
    end
    check("core_rst_before_csum", core_rst_, 0);
    send_byte(bad_csum ? 8'h00 : cs, thr);
    check("sb_drained", sb.size(), 0);
    check("rx_ready_after_csum", rx_ready, 0);
    check("busy_after_csum", busy, 0);
    check("core_rst_after_csum", core_rst_, !bad_csum);
    check("done_after_csum", done, !bad_csum);
    check("err_after_csum", err_code, bad_csum ? 2'b01 : 2'b00);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, {core_rst_, rx_ready, imem_we, busy, done, err_code}, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
  endtask
  task automatic bad_len(input logic [15:0] n);
    int w0;
    w0 = we_cnt;
    do_start();
    check("err_cleared_on_start", err_code, 0);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    check("bad_len_err", err_code, 2'b10);
    check("bad_len_rx_ready", rx_ready, 0);
    check("bad_len_busy", busy, 0);
    check("bad_len_core_rst", core_rst_, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bad_len_no_we", we_cnt, w0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    rx_valid = 1'b0;
    check("start_rx_ready", rx_ready, 1);
    check("start_busy", busy, 1);
    send_image(1'b0, 1'b0);
    do_start();
    check("reload_core_rst", core_rst_, 0);
    check("reload_done", done, 0);
    check("reload_busy", busy, 1);
    send_image(1'b0, 1'b1);
    bad_len(16'd0);
    bad_len(16'(IMEM_DEPTH + 1));
    do_start();
    send_image(1'b1, 1'b0);
    do_start();
    sb.push_back({ADDR_W'(0), img[0]});
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b0);
    send_byte(img[1][7:0], 1'b0);
    check("mid_busy", busy, 1);
    #1 rst_ = 1'b0;
    #1 check_reset_vals("async_reset");
    @(posedge clk);
    #1 rst_ = 1'b1;
    check("reset_sb_drained", sb.size(), 0);
    do_start();
    send_image(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
